buffer_drain: RTL and testbench
===============================

# buffer_drain

Reader side of the router input buffer. It pops flits from an input buffer through the buffer's read/empty/valid handshake and holds them in a 2-entry output queue. It forwards them to the switch/output link over a valid/ready handshake and marks packet boundaries (SOP/EOP) from the header-flit length field. It sits between one input buffer and the crossbar arbiter request logic, one instance per input port.

## Interface
- DATA_WIDTH, 16, flit width in bits; must match the input buffer.
- LEN_WIDTH, 4, width of the body-flit count field in header flit bits [LEN_WIDTH-1:0].
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset; one clock, shared with the input buffer.
- buf_empty_i  input  1  input buffer holds no flits.
- buf_read_o  output  1  pop request to the input buffer (one flit per cycle asserted).
- buf_valid_i  input  1  read data valid; returns exactly one cycle after buf_read_o.
- buf_data_i  input  DATA_WIDTH  read data, sampled only when buf_valid_i=1.
- out_valid_o  output  1  queue head holds a flit.
- out_ready_i  input  1  downstream accepts the head flit this cycle.
- out_data_o  output  DATA_WIDTH  head flit.
- out_sop_o  output  1  head flit is a packet header; qualified by out_valid_o.
- out_eop_o  output  1  head flit is the last flit of its packet; qualified by out_valid_o.
- pkt_count_o  output  8  completed packets forwarded; wraps 255->0.
- err_o  output  1  sticky protocol error.

## Operation
- Output queue: 2 entries of DATA_WIDTH, FIFO order. count is 0..2. inflight is 0..1 (reads issued last cycle).
- pop = out_valid_o && out_ready_i. A pop removes the head at the clock edge.
- buf_read_o = !reset && !buf_empty_i && (count + inflight - pop) < 2. This is combinational; it counts the same-cycle pop as a free slot.
- inflight is set to buf_read_o each cycle.
- On buf_valid_i=1 with inflight=1, buf_data_i is written at the tail. A simultaneous pop and write is allowed at any count.
- If buf_valid_i=1 with inflight=0, the flit is dropped and err_o is set. err_o clears only on reset.
- The queue never overflows by construction. If a write would exceed 2 entries, that is an implementation bug and is covered by an assertion.
- Framing FSM, advanced only on pop:
  - HEAD: head flit is a header, out_sop_o=1. Let L = out_data_o[LEN_WIDTH-1:0].
    - L=0: out_eop_o=1, stay in HEAD.
    - L>0: out_eop_o=0, set remaining=L, go to BODY.
  - BODY: out_sop_o=0, out_eop_o=(remaining==1). Each pop decrements remaining. The pop with remaining==1 returns to HEAD.
- pkt_count_o increments on every pop with out_eop_o=1, modulo 256.
- out_data_o, out_sop_o and out_eop_o are don't-care when out_valid_o=0. The bench must not check them then.
- Reset values:
  - buf_read_o=0, out_valid_o=0, out_sop_o=0, out_eop_o=0
  - out_data_o=0, pkt_count_o=0, err_o=0
  - count=0, inflight=0, FSM=HEAD, remaining=0
- Reset mid-packet discards queued and in-flight flits and restarts framing in HEAD. The upstream buffer resets on the same edge.

## Timing
- Read issued in cycle t; data returns in t+1; the flit is visible at out_valid_o in t+2. Minimum latency from buffer to output is 2 cycles.
- Sustained throughput is 1 flit/cycle while buf_empty_i=0 and out_ready_i=1.
- out_valid_o, out_data_o, out_sop_o and out_eop_o come from registers and the FSM state only. There is no combinational path from buf_* to out_*.
- buf_read_o depends combinationally on out_ready_i.
- out_valid_o=1 must hold, with stable data, until it is popped (standard valid/ready rule).
- The first cycle after reset deassertion may issue a read.

## Test plan
- Single header, L=0 (data 16'h00A0), out_ready_i=1: buf_read_o in cycle 1, out_valid_o in cycle 3 with sop=1, eop=1, pkt_count_o=1.
- Packet with header L=3 plus 3 body flits, continuous ready: 4 consecutive output cycles with sop pattern 1,0,0,0 and eop pattern 0,0,0,1. No idle cycles after the first output.
- Backpressure: buffer holds 6 flits, out_ready_i=0 for 10 cycles. Exactly 2 reads are issued, count=2, buf_read_o stays 0. On releasing ready, flits arrive in order with no loss or duplication.
- Alternating out_ready_i 1/0 with a long packet (L=15, 16 flits): all flits are delivered in order and eop falls on the 16th flit. Verifies simultaneous pop and write at count=1 and count=2.
- Spurious buf_valid_i=1 with no prior read: err_o=1 next cycle and stays 1 until reset. The queue is unchanged.
- Reset asserted in BODY with remaining=2: after reset all outputs are 0 and the FSM is in HEAD. The next flit received is treated as a header (sop=1). pkt_count_o=0 after 255->0 wrap check using 256 L=0 packets.

Source files
------------

// File: rtl/buffer_drain.sv
// Reader side of a router input buffer: pops flits into a 2-entry output queue,
// forwards them over valid/ready and frames packets from the header length field.
module buffer_drain #(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned LEN_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  buf_empty_i,
   output logic                  buf_read_o,
   input  logic                  buf_valid_i,
   input  logic [DATA_WIDTH-1:0] buf_data_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] out_data_o,
   output logic                  out_sop_o,
   output logic                  out_eop_o,
   output logic [7:0]            pkt_count_o,
   output logic                  err_o
);

   localparam int unsigned DEPTH = 2;
   localparam int unsigned CNT_W = 2;
   localparam int unsigned OCC_W = 3;

   typedef enum logic {
      ST_HEAD,
      ST_BODY
   } state_e;

   logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_d;
   logic [CNT_W-1:0]                 count_q, count_d;
   logic                             valid_q, valid_d;
   logic                             inflight_q, inflight_d;
   state_e                           state_q, state_d;
   logic [LEN_WIDTH-1:0]             rem_q, rem_d;
   logic [7:0]                       pkt_q, pkt_d;
   logic                             err_q, err_d;

   logic                 pop;
   logic                 wr;
   logic [CNT_W-1:0]     cnt_after;
   logic [OCC_W-1:0]     occ;
   logic [LEN_WIDTH-1:0] head_len;

   // Output view: head entry plus framing flags derived from FSM state.
   always_comb begin
      head_len    = data_q[0][LEN_WIDTH-1:0];
      out_valid_o = valid_q;
      out_data_o  = data_q[0];
      out_sop_o   = valid_q && (state_q == ST_HEAD);
      out_eop_o   = valid_q && ((state_q == ST_HEAD) ? (head_len == '0)
                                                     : (rem_q == LEN_WIDTH'(1)));
      pkt_count_o = pkt_q;
      err_o       = err_q;
   end

   // Queue, read issue and error tracking. A same-cycle pop frees a slot.
   always_comb begin
      data_d     = data_q;
      count_d    = count_q;
      valid_d    = valid_q;
      inflight_d = inflight_q;
      err_d      = err_q;

      pop        = valid_q && out_ready_i;
      occ        = OCC_W'(count_q) + OCC_W'(inflight_q);
      buf_read_o = !reset && !buf_empty_i && (occ < (OCC_W'(DEPTH) + OCC_W'(pop)));
      wr         = buf_valid_i && inflight_q;
      cnt_after  = count_q - CNT_W'(pop);

      if (pop) begin
         data_d[0] = data_q[1];
      end
      if (wr && (cnt_after < CNT_W'(DEPTH))) begin
         data_d[cnt_after[0]] = buf_data_i;
      end
      count_d    = cnt_after + CNT_W'(wr);
      valid_d    = (count_d != '0);
      inflight_d = buf_read_o;
      if (buf_valid_i && !inflight_q) begin
         err_d = 1'b1;
      end
   end

   // Framing FSM and packet counter, advanced only by pops.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      pkt_d   = pkt_q;

      if (pop) begin
         if (state_q == ST_HEAD) begin
            if (head_len != '0) begin
               state_d = ST_BODY;
               rem_d   = head_len;
            end
         end else begin
            rem_d = rem_q - LEN_WIDTH'(1);
            if (rem_q == LEN_WIDTH'(1)) begin
               state_d = ST_HEAD;
            end
         end
         if (out_eop_o) begin
            pkt_d = pkt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q     <= '0;
         count_q    <= '0;
         valid_q    <= 1'b0;
         inflight_q <= 1'b0;
         state_q    <= ST_HEAD;
         rem_q      <= '0;
         pkt_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         data_q     <= data_d;
         count_q    <= count_d;
         valid_q    <= valid_d;
         inflight_q <= inflight_d;
         state_q    <= state_d;
         rem_q      <= rem_d;
         pkt_q      <= pkt_d;
         err_q      <= err_d;
      end
   end

   // Read issue is throttled so a write can never land on a full queue.
   always_ff @(posedge clk) begin
      if (!reset) begin
         assert (!(wr && (cnt_after == CNT_W'(DEPTH))));
      end
   end

endmodule

// File: tb/tb_buffer_drain.sv
// Self-checking bench for buffer_drain: models the upstream buffer and checks the
// output stream against a packet-level scoreboard.
module tb_buffer_drain;

   logic        clk = 1'b0;
   logic        reset;
   logic        buf_empty_i;
   logic        buf_read_o;
   logic        buf_valid_i;
   logic [15:0] buf_data_i;
   logic        out_valid_o;
   logic        out_ready_i;
   logic [15:0] out_data_o;
   logic        out_sop_o;
   logic        out_eop_o;
   logic [7:0]  pkt_count_o;
   logic        err_o;

   always #5 clk = ~clk;

   buffer_drain #(.DATA_WIDTH(16), .LEN_WIDTH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .buf_empty_i (buf_empty_i),
      .buf_read_o  (buf_read_o),
      .buf_valid_i (buf_valid_i),
      .buf_data_i  (buf_data_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .out_data_o  (out_data_o),
      .out_sop_o   (out_sop_o),
      .out_eop_o   (out_eop_o),
      .pkt_count_o (pkt_count_o),
      .err_o       (err_o)
   );

   typedef struct packed {
      logic [15:0] d;
      logic        sop;
      logic        eop;
   } flit_t;

   logic [15:0] bufq[$];
   flit_t       expq[$];
   int          errors = 0;
   int          checks = 0;
   logic [7:0]  exp_pkts;
   logic        exp_err;
   logic        pend_v;
   logic [15:0] pend_d;
   logic        spur;
   int          outstanding;
   logic        prev_hold;
   logic [15:0] prev_data;
   int          cyc;
   logic        t_read, t_valid, t_pop;

   task automatic push_pkt(input int unsigned len);
      logic [15:0] fd;
      fd = 16'($urandom);
      fd[3:0] = 4'(len);
      bufq.push_back(fd);
      expq.push_back('{d: fd, sop: 1'b1, eop: (len == 0)});
      for (int i = 1; i <= int'(len); i++) begin
         fd = 16'($urandom);
         bufq.push_back(fd);
         expq.push_back('{d: fd, sop: 1'b0, eop: (i == int'(len))});
      end
   endtask

   // One clock: drive at negedge, sample #1 later, score pops and model the buffer.
   task automatic tick(input logic rdy);
      flit_t e;
      @(negedge clk);
      out_ready_i = rdy;
      buf_empty_i = (bufq.size() == 0);
      buf_valid_i = pend_v | spur;
      buf_data_i  = spur ? 16'hDEAD : pend_d;
      #1;
      cyc++;
      if (prev_hold) begin
         checks++;
         if (out_valid_o !== 1'b1 || out_data_o !== prev_data) begin
            errors++;
            $display("FAIL hold: valid=%b data=%h, expected valid=1 data=%h", out_valid_o, out_data_o, prev_data);
         end
      end
      checks++;
      if (pkt_count_o !== exp_pkts) begin
         errors++;
         $display("FAIL pkt_count: got %0d expected %0d", pkt_count_o, exp_pkts);
      end
      checks++;
      if (err_o !== exp_err) begin
         errors++;
         $display("FAIL err: got %b expected %b", err_o, exp_err);
      end
      t_read  = buf_read_o;
      t_valid = out_valid_o;
      t_pop   = out_valid_o && rdy;
      if (t_pop) begin
         checks++;
         if (expq.size() == 0) begin
            errors++;
            $display("FAIL pop: got flit %h, expected no flit", out_data_o);
         end else begin
            e = expq.pop_front();
            if ({out_data_o, out_sop_o, out_eop_o} !== {e.d, e.sop, e.eop}) begin
               errors++;
               $display("FAIL flit: got data=%h sop=%b eop=%b expected data=%h sop=%b eop=%b",
                        out_data_o, out_sop_o, out_eop_o, e.d, e.sop, e.eop);
            end
            if (e.eop) exp_pkts = exp_pkts + 8'd1;
         end
      end
      if (t_read) begin
         checks++;
         if (bufq.size() == 0) begin
            errors++;
            $display("FAIL read_empty: got buf_read_o=1 expected 0 while empty");
         end else begin
            pend_d = bufq.pop_front();
         end
      end
      pend_v = t_read;
      outstanding = outstanding + int'(t_read) - int'(t_pop);
      checks++;
      if (outstanding > 2) begin
         errors++;
         $display("FAIL occupancy: got %0d held+inflight expected <=2", outstanding);
      end
      if (spur) exp_err = 1'b1;
      prev_hold = out_valid_o && !rdy;
      prev_data = out_data_o;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      buf_valid_i = 1'b0;
      buf_empty_i = 1'b0;
      out_ready_i = 1'b1;
      spur = 1'b0;
      pend_v = 1'b0;
      bufq.delete();
      expq.delete();
      exp_pkts = 8'd0;
      exp_err = 1'b0;
      outstanding = 0;
      prev_hold = 1'b0;
      @(negedge clk);
      #1;
   endtask

   task automatic release_reset();
      reset = 1'b0;
      buf_empty_i = 1'b1;
      cyc = 0;
   endtask

   task automatic drain(input int maxc, input string nm);
      for (int i = 0; i < maxc && expq.size() != 0; i++) tick(1'b1);
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL %s_drain: got %0d flits left expected 0", nm, expq.size());
      end
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (buf_read_o !== 1'b0) begin
         errors++;
         $display("FAIL reset_read: got %b expected 0", buf_read_o);
      end
      checks++;
      if ({out_valid_o, out_sop_o, out_eop_o, out_data_o, pkt_count_o, err_o} !== 28'd0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0",
                  {out_valid_o, out_sop_o, out_eop_o, out_data_o, pkt_count_o, err_o});
      end
      release_reset();
      tick(1'b1);
      checks++;
      if (buf_read_o !== 1'b0 || out_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL idle: got read=%b valid=%b expected 0 0", buf_read_o, out_valid_o);
      end
   endtask

   task automatic test_single();
      int rd_c, vd_c;
      logic [15:0] fd;
      do_reset();
      release_reset();
      fd = 16'h00A0;
      bufq.push_back(fd);
      expq.push_back('{d: fd, sop: 1'b1, eop: 1'b1});
      rd_c = 0;
      vd_c = 0;
      for (int c = 1; c <= 5; c++) begin
         tick(1'b1);
         if (t_read && rd_c == 0) rd_c = c;
         if (t_valid && vd_c == 0) vd_c = c;
      end
      checks++;
      if (rd_c != 1 || vd_c != 3) begin
         errors++;
         $display("FAIL single_latency: got read@%0d valid@%0d expected read@1 valid@3", rd_c, vd_c);
      end
      checks++;
      if (pkt_count_o !== 8'd1) begin
         errors++;
         $display("FAIL single_count: got %0d expected 1", pkt_count_o);
      end
   endtask

   task automatic test_packet();
      int first, last, n;
      push_pkt(3);
      first = -1;
      last = -1;
      n = 0;
      for (int i = 0; i < 20 && expq.size() != 0; i++) begin
         tick(1'b1);
         if (t_pop) begin
            if (first < 0) first = cyc;
            last = cyc;
            n++;
         end
      end
      checks++;
      if (n != 4 || last - first != 3) begin
         errors++;
         $display("FAIL packet_stream: got %0d pops over %0d cycles expected 4 over 4", n, last - first + 1);
      end
   endtask

   task automatic test_backpressure();
      int reads;
      push_pkt(5);
      reads = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1'b0);
         reads += int'(t_read);
      end
      checks++;
      if (reads != 2 || bufq.size() != 4 || t_read !== 1'b0) begin
         errors++;
         $display("FAIL backpressure_reads: got reads=%0d left=%0d read=%b expected 2 4 0",
                  reads, bufq.size(), t_read);
      end
      checks++;
      if (out_valid_o !== 1'b1 || out_sop_o !== 1'b1) begin
         errors++;
         $display("FAIL backpressure_head: got valid=%b sop=%b expected 1 1", out_valid_o, out_sop_o);
      end
      drain(40, "backpressure");
   endtask

   task automatic test_alternating();
      push_pkt(15);
      for (int i = 0; i < 200 && expq.size() != 0; i++) tick(i % 2 == 0);
      checks++;
      if (expq.size() != 0) begin
         errors++;
         $display("FAIL alternating: got %0d flits left expected 0", expq.size());
      end
   endtask

   task automatic test_random();
      int left;
      left = 8;
      for (int i = 0; i < 800 && (left > 0 || expq.size() != 0); i++) begin
         if (left > 0 && $urandom_range(0, 3) == 0) begin
            push_pkt($urandom_range(0, 15));
            left--;
         end
         tick($urandom_range(0, 3) != 0);
      end
      checks++;
      if (left != 0 || expq.size() != 0) begin
         errors++;
         $display("FAIL random: got %0d pkts unsent %0d flits left expected 0 0", left, expq.size());
      end
   endtask

   task automatic test_spurious();
      tick(1'b1);
      tick(1'b1);
      spur = 1'b1;
      tick(1'b1);
      spur = 1'b0;
      tick(1'b1);
      checks++;
      if (err_o !== 1'b1 || out_valid_o !== 1'b0) begin
         errors++;
         $display("FAIL spurious: got err=%b valid=%b expected 1 0", err_o, out_valid_o);
      end
      push_pkt(1);
      drain(20, "spurious");
      tick(1'b1);
   endtask

   task automatic test_reset_mid();
      int pops;
      logic got;
      push_pkt(4);
      pops = 0;
      for (int i = 0; i < 30 && pops < 3; i++) begin
         tick(1'b1);
         pops += int'(t_pop);
      end
      tick(1'b0);
      checks++;
      if (out_valid_o !== 1'b1 || out_sop_o !== 1'b0 || out_eop_o !== 1'b0) begin
         errors++;
         $display("FAIL mid_body: got valid=%b sop=%b eop=%b expected 1 0 0", out_valid_o, out_sop_o, out_eop_o);
      end
      do_reset();
      checks++;
      if ({buf_read_o, out_valid_o, out_sop_o, out_eop_o, out_data_o, pkt_count_o, err_o} !== 29'd0) begin
         errors++;
         $display("FAIL mid_reset: got %h expected 0",
                  {buf_read_o, out_valid_o, out_sop_o, out_eop_o, out_data_o, pkt_count_o, err_o});
      end
      release_reset();
      push_pkt(0);
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
         tick(1'b1);
         if (t_valid) begin
            got = 1'b1;
            checks++;
            if (out_sop_o !== 1'b1) begin
               errors++;
               $display("FAIL mid_header: got sop=%b expected 1", out_sop_o);
            end
         end
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL mid_timeout: got no flit expected one");
      end
      drain(10, "mid");
   endtask

   task automatic test_wrap();
      do_reset();
      release_reset();
      for (int i = 0; i < 256; i++) push_pkt(0);
      drain(600, "wrap");
      tick(1'b1);
      tick(1'b1);
      checks++;
      if (pkt_count_o !== 8'd0) begin
         errors++;
         $display("FAIL wrap: got %0d expected 0", pkt_count_o);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      buf_empty_i = 1'b1;
      buf_valid_i = 1'b0;
      buf_data_i = 16'h0;
      out_ready_i = 1'b0;
      spur = 1'b0;
      pend_v = 1'b0;
      pend_d = 16'h0;
      exp_pkts = 8'd0;
      exp_err = 1'b0;
      outstanding = 0;
      prev_hold = 1'b0;
      prev_data = 16'h0;
      cyc = 0;
      test_reset();
      test_single();
      test_packet();
      test_backpressure();
      test_alternating();
      test_random();
      test_spurious();
      test_reset_mid();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
